note_sequencer: RTL and testbench

// - Step sequencer that drives the note synthesizer. Plays a programmable

---
 rtl/note_sequencer.sv | 168 ++++++++++++++++
 tb/tb_note_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody step sequencer: plays a note table through note/octave/gate outputs,
// with play/pause and stop keys, tempo scaling and optional looping.
module note_sequencer #(
  parameter int unsigned clk_mhz     = 50,
  parameter int unsigned n_steps     = 16,
  parameter int unsigned beat_cycles = clk_mhz * 1000 * 125,
  parameter int unsigned gap_cycles  = clk_mhz * 1000 * 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 key,
  input  logic [1:0]                 tempo,
  input  logic                       loop,
  input  logic                       wr_en,
  input  logic [$clog2(n_steps)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  output logic [3:0]                 note,
  output logic [1:0]                 octave,
  output logic                       gate,
  output logic [$clog2(n_steps)-1:0] step,
  output logic                       playing,
  output logic                       paused
);

  localparam int unsigned SW = $clog2(n_steps);
  localparam int unsigned CW = $clog2(16 * beat_cycles + gap_cycles + 1);
  localparam logic [CW-1:0] BEAT = CW'(beat_cycles);
  localparam logic [CW-1:0] GAP  = CW'(gap_cycles);
  localparam logic [SW-1:0] LAST = SW'(n_steps - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSE} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   step_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      note_n;
  logic [1:0]      octave_n;
  logic            sound, sound_n;
  logic [1:0]      key_prev;
  logic            play_ev, stop_ev;

  logic [7:0]      mem [n_steps];
  logic [7:0]      rd_data;

  logic [3:0]      code;
  logic            is_end, is_note;
  logic [2:0]      beats, tempo_p1;
  logic [4:0]      mult;
  logic [CW-1:0]   dur;

  // Read address is the next step so the entry is ready during LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[step_n];
  end

  always_comb begin
    code     = rd_data[7:4];
    is_end   = (code == 4'd14);
    is_note  = (code < 4'd12);
    beats    = {1'b0, rd_data[1:0]} + 3'd1;
    tempo_p1 = {1'b0, tempo} + 3'd1;
    mult     = 5'(beats) * 5'(tempo_p1);
    dur      = CW'(mult) * BEAT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      note     <= '0;
      octave   <= '0;
      sound    <= 1'b0;
      key_prev <= '0;
      play_ev  <= 1'b0;
      stop_ev  <= 1'b0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      cnt      <= cnt_n;
      note     <= note_n;
      octave   <= octave_n;
      sound    <= sound_n;
      key_prev <= key;
      play_ev  <= key[0] & ~key_prev[0];
      stop_ev  <= key[1] & ~key_prev[1];
    end
  end

  always_comb begin
    state_n  = state;
    step_n   = step;
    cnt_n    = cnt;
    note_n   = note;
    octave_n = octave;
    sound_n  = sound;
    if (stop_ev) begin
      state_n = IDLE;
      step_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play_ev) begin
            state_n = LOAD;
            step_n  = '0;
          end
        end
        LOAD: begin
          if (is_end) begin
            if (loop && step != '0) step_n = '0;
            else                    state_n = IDLE;
          end else begin
            state_n = PLAY;
            cnt_n   = dur;
            sound_n = is_note;
            if (is_note) begin
              note_n   = code;
              octave_n = rd_data[3:2];
            end
          end
        end
        PLAY: begin
          // The pausing cycle still counts as played; a pause on the last
          // cycle keeps one cycle for after resume.
          if (play_ev) begin
            state_n = PAUSE;
            if (cnt > CW'(1)) cnt_n = cnt - CW'(1);
          end else if (cnt <= CW'(1)) begin
            if (step == LAST) begin
              if (loop) begin
                step_n  = '0;
                state_n = LOAD;
              end else begin
                state_n = IDLE;
              end
            end else begin
              step_n  = step + SW'(1);
              state_n = LOAD;
            end
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        PAUSE: begin
          if (play_ev) state_n = PLAY;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    gate    = 1'b0;
    playing = 1'b0;
    paused  = 1'b0;
    unique case (state)
      LOAD:    playing = 1'b1;
      PLAY: begin
        playing = 1'b1;
        gate    = sound && (cnt > GAP);
      end
      PAUSE:   paused = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with beat_cycles=10, gap_cycles=2.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] tempo;
  logic       loop;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] note;
  logic [1:0] octave;
  logic       gate;
  logic [3:0] step;
  logic       playing;
  logic       paused;

  int n_cmp = 0;
  int n_err = 0;

  note_sequencer #(
    .clk_mhz    (50),
    .n_steps    (16),
    .beat_cycles(10),
    .gap_cycles (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .tempo  (tempo),
    .loop   (loop),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .note   (note),
    .octave (octave),
    .gate   (gate),
    .step   (step),
    .playing(playing),
    .paused (paused)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] m);
    key = m;
    @(negedge clk);
    key = 2'b00;
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic load_chk(input int s, input int nt);
    cyc();
    check("load_playing", playing, 1);
    check("load_gate", gate, 0);
    check("load_step", step, s);
    check("load_note", note, nt);
  endtask

  task automatic run_note(input int nt, input int oc, input int s,
                          input int first, input int n, input bit snd);
    for (int i = 0; i < n; i++) begin
      int c;
      cyc();
      c = first - i;
      check($sformatf("gate_s%0d_c%0d", s, c), gate, (snd && c > 2));
      check($sformatf("note_s%0d_c%0d", s, c), note, nt);
      check($sformatf("octave_s%0d_c%0d", s, c), octave, oc);
      check($sformatf("step_s%0d_c%0d", s, c), step, s);
      check($sformatf("playing_s%0d_c%0d", s, c), playing, 1);
    end
  endtask

  task automatic idle_chk(input string tag, input int s, input int nt, input int oc);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_paused"}, paused, 0);
    check({tag, "_gate"}, gate, 0);
    check({tag, "_step"}, step, s);
    check({tag, "_note"}, note, nt);
    check({tag, "_octave"}, octave, oc);
  endtask

  initial begin
    rst = 1'b0; key = '0; tempo = '0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) cyc();
    rst = 1'b1;
    idle_chk("reset", 0, 0, 0);

    // One-shot melody: note 3 one beat, note 7 two beats, END.
    wr(0, 'h30); wr(1, 'h71); wr(2, 'hE0);
    press(2'b01);
    load_chk(0, 0);
    run_note(3, 0, 0, 10, 10, 1);
    load_chk(1, 3);
    run_note(7, 0, 1, 20, 20, 1);
    load_chk(2, 7);
    cyc();
    idle_chk("end_noloop", 2, 7, 0);

    // Looping: END at step 2 wraps to step 0 via a second LOAD.
    loop = 1'b1;
    press(2'b01);
    load_chk(0, 7);
    run_note(3, 0, 0, 10, 10, 1);
    load_chk(1, 3);
    run_note(7, 0, 1, 20, 20, 1);
    load_chk(2, 7);
    load_chk(0, 7);

    // Pause after 4 played cycles of step 0, hold, resume for the remaining 6.
    run_note(3, 0, 0, 10, 3, 1);
    press(2'b01);
    check("pre_pause_gate", gate, 1);
    check("pre_pause_playing", playing, 1);
    cyc();
    check("pause_paused", paused, 1);
    check("pause_playing", playing, 0);
    check("pause_gate", gate, 0);
    repeat (99) begin
      cyc();
      check("pause_hold_gate", gate, 0);
      check("pause_hold_paused", paused, 1);
    end
    press(2'b01);
    check("resume_pending_paused", paused, 1);
    run_note(3, 0, 0, 6, 6, 1);
    load_chk(1, 3);
    run_note(7, 0, 1, 20, 5, 1);

    // Stop and play edges together: stop wins.
    press(2'b11);
    cyc();
    idle_chk("stop_play", 0, 7, 0);
    repeat (3) cyc();
    idle_chk("stop_stays", 0, 7, 0);

    // END at step 0 goes IDLE even with loop set.
    wr(0, 'hE0);
    press(2'b01);
    load_chk(0, 7);
    cyc();
    idle_chk("end_step0", 0, 7, 0);

    // tempo=3 rest of 2 beats (80 cycles); rewrite entry 1 while step 0 plays.
    wr(0, 'hF1);
    tempo = 2'd3;
    loop  = 1'b0;
    press(2'b01);
    load_chk(0, 7);
    run_note(7, 0, 0, 80, 40, 0);
    wr(1, 'hB9);
    run_note(7, 0, 0, 39, 39, 0);
    load_chk(1, 7);
    run_note(11, 2, 1, 80, 80, 1);
    load_chk(2, 11);
    cyc();
    idle_chk("end_tempo3", 2, 11, 2);

    // Reset in the middle of a sounding note; table must survive.
    tempo = 2'd0;
    press(2'b01);
    load_chk(0, 11);
    run_note(11, 2, 0, 20, 20, 0);
    load_chk(1, 11);
    run_note(11, 2, 1, 20, 5, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    idle_chk("mid_reset", 0, 0, 0);
    press(2'b01);
    load_chk(0, 0);
    run_note(0, 0, 0, 20, 20, 0);
    load_chk(1, 0);
    run_note(11, 2, 1, 20, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
